// File: rtl/pipe_issue_sched.sv
// Purpose : round-robin issue scheduler with a RAW-hazard shift-register scoreboard
//           for a DEPTH-cycle ALU/writeback pipeline.
// Latency : 1 cycle from handshake (req_valid & req_ready) to iss_valid.
// Backpressure: req_ready is a combinational one-hot grant; a hazard-blocked or
//           unchosen requester holds its fields until it sees req_ready.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready            per-requester handshake (NREQ bits)
//   req_rs1/rs2/rd/func/addr       packed per-requester instruction fields
//   iss_valid, iss_rs1..iss_addr   registered issued instruction
//   iss_src                        index of the issued requester
//   busy_mask                      registers pending in the scoreboard
//   stall_cnt                      saturating count of all-blocked cycles
module pipe_issue_sched #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 3,
  parameter int SW    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*4-1:0] req_rs1,
  input  logic [NREQ*4-1:0] req_rs2,
  input  logic [NREQ*4-1:0] req_rd,
  input  logic [NREQ*2-1:0] req_func,
  input  logic [NREQ*8-1:0] req_addr,
  output logic              iss_valid,
  output logic [3:0]        iss_rs1,
  output logic [3:0]        iss_rs2,
  output logic [3:0]        iss_rd,
  output logic [1:0]        iss_func,
  output logic [7:0]        iss_addr,
  output logic [SW-1:0]     iss_src,
  output logic [15:0]       busy_mask,
  output logic [15:0]       stall_cnt
);

  // Scoreboard: slot 0 receives this cycle's grant, slot DEPTH-1 retires next edge.
  logic [DEPTH-1:0] sb_v;
  logic [3:0]       sb_rd [DEPTH];

  logic [SW-1:0]    ptr;
  logic [NREQ-1:0]  elig;
  logic             grant_any;
  logic [SW-1:0]    grant_idx;
  logic [3:0]       g_rs1, g_rs2, g_rd;
  logic [1:0]       g_func;
  logic [7:0]       g_addr;

  always_comb begin
    busy_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (sb_v[k]) busy_mask[sb_rd[k]] = 1'b1;
    end
  end

  // Only source operands are checked; WAW is harmless in an in-order pipe.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] & ~busy_mask[req_rs1[4*i +: 4]] & ~busy_mask[req_rs2[4*i +: 4]];
    end
  end

  // First eligible requester at or after ptr, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    g_rs1     = '0;
    g_rs2     = '0;
    g_rd      = '0;
    g_func    = '0;
    g_addr    = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_any && elig[idx]) begin
        grant_any = 1'b1;
        grant_idx = SW'(idx);
        g_rs1     = req_rs1[4*idx +: 4];
        g_rs2     = req_rs2[4*idx +: 4];
        g_rd      = req_rd[4*idx +: 4];
        g_func    = req_func[2*idx +: 2];
        g_addr    = req_addr[8*idx +: 8];
      end
    end
  end

  // Gated by rst_n so no handshake can appear while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (grant_any && rst_n) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_v      <= '0;
      for (int k = 0; k < DEPTH; k++) sb_rd[k] <= '0;
      ptr       <= '0;
      iss_valid <= 1'b0;
      iss_rs1   <= '0;
      iss_rs2   <= '0;
      iss_rd    <= '0;
      iss_func  <= '0;
      iss_addr  <= '0;
      iss_src   <= '0;
      stall_cnt <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        sb_v[k]  <= sb_v[k-1];
        sb_rd[k] <= sb_rd[k-1];
      end
      sb_v[0]   <= grant_any;
      sb_rd[0]  <= g_rd;
      iss_valid <= grant_any;
      if (grant_any) begin
        iss_rs1  <= g_rs1;
        iss_rs2  <= g_rs2;
        iss_rd   <= g_rd;
        iss_func <= g_func;
        iss_addr <= g_addr;
        iss_src  <= grant_idx;
        ptr      <= (grant_idx == SW'(NREQ-1)) ? '0 : grant_idx + SW'(1);
      end
      // A valid request without any grant means every valid requester is hazard-blocked.
      if ((|req_valid) && !grant_any && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_issue_sched.sv
module tb_pipe_issue_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance (DEPTH 3)
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_rs1, req_rs2, req_rd;
  logic [7:0]  req_func;
  logic [31:0] req_addr;
  logic        iss_valid;
  logic [3:0]  iss_rs1, iss_rs2, iss_rd;
  logic [1:0]  iss_func;
  logic [7:0]  iss_addr;
  logic [1:0]  iss_src;
  logic [15:0] busy_mask, stall_cnt;

  // Deep-pipeline instance used only for stall counter saturation
  logic [3:0]  s_req_valid;
  logic [3:0]  s_req_ready;
  logic [15:0] s_req_rs1, s_req_rs2, s_req_rd;
  logic [7:0]  s_req_func;
  logic [31:0] s_req_addr;
  logic        s_iss_valid;
  logic [3:0]  s_iss_rs1, s_iss_rs2, s_iss_rd;
  logic [1:0]  s_iss_func;
  logic [7:0]  s_iss_addr;
  logic [1:0]  s_iss_src;
  logic [15:0] s_busy_mask, s_stall_cnt;

  pipe_issue_sched #(.NREQ(4), .DEPTH(3), .SW(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .req_func(req_func), .req_addr(req_addr),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_func(iss_func), .iss_addr(iss_addr), .iss_src(iss_src),
    .busy_mask(busy_mask), .stall_cnt(stall_cnt)
  );

  pipe_issue_sched #(.NREQ(4), .DEPTH(15), .SW(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_rs1(s_req_rs1), .req_rs2(s_req_rs2), .req_rd(s_req_rd),
    .req_func(s_req_func), .req_addr(s_req_addr),
    .iss_valid(s_iss_valid), .iss_rs1(s_iss_rs1), .iss_rs2(s_iss_rs2), .iss_rd(s_iss_rd),
    .iss_func(s_iss_func), .iss_addr(s_iss_addr), .iss_src(s_iss_src),
    .busy_mask(s_busy_mask), .stall_cnt(s_stall_cnt)
  );

  // Per-requester stimulus fields for the main instance
  logic       v  [4];
  logic [3:0] rs1[4], rs2[4], rd[4];
  logic [1:0] fn [4];
  logic [7:0] ad [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_valid[i]       = v[i];
      req_rs1[4*i +: 4]  = rs1[i];
      req_rs2[4*i +: 4]  = rs2[i];
      req_rd[4*i +: 4]   = rd[i];
      req_func[2*i +: 2] = fn[i];
      req_addr[8*i +: 8] = ad[i];
    end
  end

  int errors = 0;
  int checks = 0;
  logic [23:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic vv, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] d, input logic [1:0] f, input logic [7:0] x);
    v[i] = vv; rs1[i] = a; rs2[i] = b; rd[i] = d; fn[i] = f; ad[i] = x;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 4'd0, 4'd0, 4'd0, 2'd0, 8'd0);
  endtask

  // One cycle: check the grant (exp_g < 0 means none), queue the expected issue,
  // then after the edge compare what the DUT issued.
  task automatic step(input string tag, input int exp_g);
    logic [23:0] e;
    logic [3:0]  onehot;
    #1;
    onehot = 4'd0;
    if (exp_g >= 0) begin
      onehot[exp_g] = 1'b1;
      exp_q.push_back({2'(exp_g), rs1[exp_g], rs2[exp_g], rd[exp_g], fn[exp_g], ad[exp_g]});
    end
    chk({tag, ".ready"}, 32'(req_ready), 32'(onehot));
    @(posedge clk); #1;
    chk({tag, ".iss_valid"}, 32'(iss_valid), (exp_g >= 0) ? 32'd1 : 32'd0);
    if (exp_g >= 0) begin
      if (exp_q.size() == 0) begin
        chk({tag, ".queue"}, 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk({tag, ".iss"}, 32'({iss_src, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr}), 32'(e));
      end
    end
  endtask

  initial begin
    clear_reqs();
    s_req_valid = '0; s_req_rs1 = '0; s_req_rs2 = '0; s_req_rd = '0;
    s_req_func = '0; s_req_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: build some state, then assert reset mid-cycle with garbage inputs
    set_req(0, 1'b1, 4'd8, 4'd9, 4'd1, 2'd2, 8'hA5);
    step("t1_pre", 0);
    for (int i = 0; i < 4; i++)
      set_req(i, 1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 2'($urandom), 8'($urandom));
    #2 rst_n = 1'b0;
    #1;
    chk("t1.iss_valid", 32'(iss_valid), 32'd0);
    chk("t1.ready",     32'(req_ready), 32'd0);
    chk("t1.busy_mask", 32'(busy_mask), 32'd0);
    chk("t1.stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    clear_reqs();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T2: round-robin over four independent requesters, starting at 0 after reset
    for (int i = 0; i < 4; i++)
      set_req(i, 1'b1, 4'(8 + i), 4'(12 + i), 4'(i), 2'(i), 8'(16 * i + 3));
    step("t2_g0", 0);
    step("t2_g1", 1);
    step("t2_g2", 2);
    step("t2_g3", 3);
    step("t2_g0b", 0);
    clear_reqs();
    repeat (3) step("t2_drain", -1);
    chk("t2.stall_cnt", 32'(stall_cnt), 32'd0);
    chk("t2.busy_mask", 32'(busy_mask), 32'd0);

    // T3: dependent op from a single requester stalls DEPTH cycles
    set_req(0, 1'b1, 4'd8, 4'd9, 4'd5, 2'd0, 8'h11);
    step("t3_prod", 0);
    set_req(0, 1'b1, 4'd5, 4'd10, 4'd6, 2'd1, 8'h55);
    repeat (3) step("t3_stall", -1);
    step("t3_cons", 0);
    chk("t3.stall_cnt", 32'(stall_cnt), 32'd3);
    clear_reqs();
    repeat (3) step("t3_drain", -1);

    // T4: an independent requester fills the slot while req0 waits
    set_req(0, 1'b1, 4'd8, 4'd9, 4'd5, 2'd0, 8'h21);
    step("t4_prod", 0);
    set_req(0, 1'b1, 4'd5, 4'd9, 4'd6, 2'd3, 8'h22);
    for (int k = 0; k < 3; k++) begin
      set_req(1, 1'b1, 4'd10, 4'd11, 4'(12 + k), 2'(k), 8'(8'h30 + k));
      step("t4_bypass", 1);
    end
    set_req(1, 1'b0, 4'd0, 4'd0, 4'd0, 2'd0, 8'd0);
    step("t4_cons", 0);
    chk("t4.stall_cnt", 32'(stall_cnt), 32'd3);
    clear_reqs();
    repeat (3) step("t4_drain", -1);
    chk("t4.busy_mask", 32'(busy_mask), 32'd0);

    // T5: busy_mask tracks each destination for exactly DEPTH edges
    set_req(2, 1'b1, 4'd8, 4'd9, 4'd2, 2'd1, 8'h40);
    step("t5_rd2", 2);
    chk("t5.mask_a", 32'(busy_mask), 32'h0004);
    set_req(2, 1'b1, 4'd10, 4'd11, 4'd9, 2'd2, 8'h41);
    step("t5_rd9", 2);
    chk("t5.mask_b", 32'(busy_mask), 32'h0204);
    clear_reqs();
    step("t5_idle", -1);
    chk("t5.mask_c", 32'(busy_mask), 32'h0204);
    step("t5_idle", -1);
    chk("t5.mask_d", 32'(busy_mask), 32'h0200);
    step("t5_idle", -1);
    chk("t5.mask_e", 32'(busy_mask), 32'h0000);

    // Register 0 is scoreboarded like any other
    set_req(3, 1'b1, 4'd8, 4'd9, 4'd0, 2'd0, 8'h50);
    step("t5_r0prod", 3);
    set_req(3, 1'b1, 4'd0, 4'd9, 4'd1, 2'd0, 8'h51);
    step("t5_r0stall", -1);
    clear_reqs();
    repeat (3) step("t5_drain", -1);

    // T6: one self-dependent requester on the DEPTH-15 instance: 1 grant + 15 stalls per 16 cycles
    s_req_valid = 4'b0001;
    s_req_rs1   = 16'h0005;
    s_req_rs2   = 16'h0005;
    s_req_rd    = 16'h0005;
    repeat (1600) @(posedge clk);
    #1;
    chk("t6.partial", 32'(s_stall_cnt), 32'd1500);
    repeat (70000) @(posedge clk);
    #1;
    chk("t6.sat", 32'(s_stall_cnt), 32'h0000FFFF);
    repeat (20) @(posedge clk);
    #1;
    chk("t6.hold", 32'(s_stall_cnt), 32'h0000FFFF);
    s_req_valid = 4'b0000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
